blink_move_ctrl: RTL and testbench

- Control FSM for the BlinkAndMove LED design: sequences the tick counter and the LED shift register.
- Synchronizes the four board switches, selects the counter rate, and gates the counter on or off.
- Turns counter ticks into shift-step pulses, bounce direction, blink phase and LED colour-bank selection.
- Sits in top_level_leds between i_sw, the counter (enable/sel/valid) and the shift register (valid).

---
 rtl/blink_move_ctrl.sv | 149 ++++++++++++++
 tb/tb_blink_move_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/blink_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blink_move_ctrl
// Purpose  : Control FSM for BlinkAndMove: switch sync, counter gating,
//            shift-step pulses, bounce direction, blink phase, colour bank.
// Revision : 1.0 - initial release
// ============================================================================
module blink_move_ctrl #(
    parameter int N_LEDS       = 4,
    parameter int BLINK_CYCLES = 3,
    parameter int N_COLORS     = 3
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [3:0] i_sw,
    input  logic       i_tick,
    output logic       o_cnt_enable,
    output logic [1:0] o_cnt_sel,
    output logic       o_step,
    output logic       o_dir,
    output logic       o_blink_on,
    output logic [1:0] o_color,
    output logic [1:0] o_state
);

    localparam int SC_W = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
    localparam int BC_W = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_BLINK  = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t            state_q;
    logic [3:0]        sw_meta_q;
    logic [3:0]        sw_s_q;
    logic [SC_W-1:0]   step_cnt_q;
    logic [BC_W-1:0]   blink_cnt_q;
    logic              wrap_pend_q;
    logic              cnt_enable_q;
    logic [1:0]        cnt_sel_q;
    logic              step_q;
    logic              dir_q;
    logic              blink_on_q;
    logic [1:0]        color_q;

    logic [1:0]        color_adv;
    logic              mode_mismatch;

    assign color_adv     = (color_q == 2'(N_COLORS - 1)) ? 2'd0 : color_q + 2'd1;
    assign mode_mismatch = sw_s_q[3] != (state_q == S_BLINK);

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            sw_meta_q    <= 4'd0;
            sw_s_q       <= 4'd0;
            step_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            wrap_pend_q  <= 1'b0;
            cnt_enable_q <= 1'b0;
            cnt_sel_q    <= 2'd0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            blink_on_q   <= 1'b0;
            color_q      <= 2'd0;
        end else begin
            sw_meta_q <= i_sw;
            sw_s_q    <= sw_meta_q;
            step_q    <= 1'b0;

            // Sweep-end effects land one cycle after the step pulse, so the
            // reversed direction travels with the following step.
            if (wrap_pend_q) begin
                dir_q       <= ~dir_q;
                color_q     <= color_adv;
                wrap_pend_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_enable_q <= 1'b0;
                    cnt_sel_q    <= sw_s_q[2:1];
                    blink_on_q   <= 1'b0;
                    if (sw_s_q[0]) state_q <= S_CHANGE;
                end
                S_CHANGE: begin
                    cnt_sel_q   <= sw_s_q[2:1];
                    step_cnt_q  <= '0;
                    blink_cnt_q <= '0;
                    blink_on_q  <= 1'b0;
                    if (!sw_s_q[0]) begin
                        state_q      <= S_IDLE;
                        cnt_enable_q <= 1'b0;
                    end else begin
                        state_q      <= sw_s_q[3] ? S_BLINK : S_MOVE;
                        cnt_enable_q <= 1'b1;
                    end
                end
                default: begin
                    if (!sw_s_q[0]) begin
                        state_q      <= S_IDLE;
                        cnt_enable_q <= 1'b0;
                    end else if (mode_mismatch) begin
                        state_q      <= S_CHANGE;
                        cnt_enable_q <= 1'b0;
                    end else begin
                        cnt_enable_q <= 1'b1;
                        if (i_tick) begin
                            // Speed only changes on a period boundary.
                            cnt_sel_q <= sw_s_q[2:1];
                            if (state_q == S_MOVE) begin
                                step_q <= 1'b1;
                                if (step_cnt_q == SC_W'(N_LEDS - 2)) begin
                                    step_cnt_q  <= '0;
                                    wrap_pend_q <= 1'b1;
                                end else begin
                                    step_cnt_q <= step_cnt_q + 1'b1;
                                end
                            end else begin
                                blink_on_q <= ~blink_on_q;
                                if (blink_on_q) begin
                                    if (blink_cnt_q == BC_W'(BLINK_CYCLES - 1)) begin
                                        blink_cnt_q <= '0;
                                        color_q     <= color_adv;
                                    end else begin
                                        blink_cnt_q <= blink_cnt_q + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign o_cnt_enable = cnt_enable_q;
    assign o_cnt_sel    = cnt_sel_q;
    assign o_step       = step_q;
    assign o_dir        = dir_q;
    assign o_blink_on   = blink_on_q;
    assign o_color      = color_q;
    assign o_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_blink_move_ctrl
// Purpose  : Directed self-checking bench for blink_move_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blink_move_ctrl;

    logic       clk;
    logic       i_rst;
    logic [3:0] i_sw;
    logic       i_tick;
    logic       o_cnt_enable;
    logic [1:0] o_cnt_sel;
    logic       o_step;
    logic       o_dir;
    logic       o_blink_on;
    logic [1:0] o_color;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_errors = 0;

    blink_move_ctrl #(
        .N_LEDS       (4),
        .BLINK_CYCLES (3),
        .N_COLORS     (3)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_sw         (i_sw),
        .i_tick       (i_tick),
        .o_cnt_enable (o_cnt_enable),
        .o_cnt_sel    (o_cnt_sel),
        .o_step       (o_step),
        .o_dir        (o_dir),
        .o_blink_on   (o_blink_on),
        .o_color      (o_color),
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive tick for one clock edge; returns at the following negedge.
    task automatic cyc(input logic tk);
        i_tick = tk;
        @(negedge clk);
        i_tick = 1'b0;
    endtask

    int exp_dir;
    int exp_color;

    initial begin
        i_rst  = 1'b0;
        i_sw   = 4'b1111;
        i_tick = 1'b0;

        // Reset held with switches on and ticks arriving
        cyc(1); cyc(0); cyc(1);
        check_eq("rst_state",  o_state, 0);
        check_eq("rst_enable", o_cnt_enable, 0);
        check_eq("rst_sel",    o_cnt_sel, 0);
        check_eq("rst_step",   o_step, 0);
        check_eq("rst_dir",    o_dir, 0);
        check_eq("rst_blink",  o_blink_on, 0);
        check_eq("rst_color",  o_color, 0);

        i_rst = 1'b1;
        cyc(0); cyc(0);
        check_eq("rel_idle", o_state, 0);
        cyc(0);
        check_eq("rel_change", o_state, 3);
        check_eq("rel_change_en", o_cnt_enable, 0);
        check_eq("rel_change_sel", o_cnt_sel, 3);
        cyc(0);
        check_eq("rel_blink", o_state, 2);
        check_eq("rel_blink_en", o_cnt_enable, 1);

        // Restart in move mode, speed 0
        i_rst = 1'b0;
        i_sw  = 4'b0001;
        cyc(0); cyc(0);
        i_rst = 1'b1;
        cyc(0); cyc(0); cyc(0);
        check_eq("mv_change", o_state, 3);
        cyc(0);
        check_eq("mv_state", o_state, 1);
        check_eq("mv_en", o_cnt_enable, 1);

        // Sweep: direction reverses every 3 steps, colour advances with it
        exp_dir   = 0;
        exp_color = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            check_eq($sformatf("sweep_step%0d", k), o_step, 1);
            check_eq($sformatf("sweep_dir%0d", k), o_dir, exp_dir);
            check_eq($sformatf("sweep_color%0d", k), o_color, exp_color);
            cyc(0);
            check_eq($sformatf("sweep_step_low%0d", k), o_step, 0);
            if (k % 3 == 0) begin
                exp_dir   = 1 - exp_dir;
                exp_color = exp_color + 1;
            end
            for (int j = 0; j < 8; j++) cyc(0);
        end
        check_eq("sweep_end_color", o_color, 2);
        check_eq("sweep_end_dir", o_dir, 0);

        // Speed change waits for a tick
        i_sw = 4'b0111;
        cyc(0); cyc(0); cyc(0); cyc(0);
        check_eq("spd_hold", o_cnt_sel, 0);
        cyc(1);
        check_eq("spd_update", o_cnt_sel, 3);
        check_eq("spd_step9", o_step, 1);
        check_eq("spd_step9_dir", o_dir, 0);
        cyc(0);
        check_eq("wrap_dir", o_dir, 1);
        check_eq("color_wrap", o_color, 0);
        for (int k = 10; k <= 12; k++) begin
            cyc(0); cyc(0);
            cyc(1);
            check_eq($sformatf("mv_step%0d", k), o_step, 1);
        end
        cyc(0);
        check_eq("mv12_color", o_color, 1);
        check_eq("mv12_dir", o_dir, 0);

        // Mode change with a tick on the transition cycle
        i_sw = 4'b1111;
        cyc(0); cyc(0);
        cyc(1);
        check_eq("mc_state", o_state, 3);
        check_eq("mc_en", o_cnt_enable, 0);
        check_eq("mc_step", o_step, 0);
        check_eq("mc_color", o_color, 1);
        cyc(0);
        check_eq("mc_blink", o_state, 2);
        check_eq("mc_blink_en", o_cnt_enable, 1);
        check_eq("mc_blink_color", o_color, 1);

        // Blink: colour advances after every 3 full on/off periods
        exp_color = 1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            if (k % 6 == 0) exp_color = (exp_color + 1) % 3;
            check_eq($sformatf("blk_on%0d", k), o_blink_on, k % 2);
            check_eq($sformatf("blk_color%0d", k), o_color, exp_color);
            check_eq($sformatf("blk_step%0d", k), o_step, 0);
            cyc(0); cyc(0);
        end

        // Back to move, then disable with a coincident tick
        i_sw = 4'b0111;
        cyc(0); cyc(0); cyc(0);
        check_eq("back_change", o_state, 3);
        cyc(0);
        check_eq("back_move", o_state, 1);
        i_sw = 4'b0110;
        cyc(0); cyc(0);
        cyc(1);
        check_eq("dis_state", o_state, 0);
        check_eq("dis_step", o_step, 0);
        check_eq("dis_en", o_cnt_enable, 0);
        cyc(0);
        check_eq("dis_step_after", o_step, 0);

        // Reset mid-run drops a pending step
        i_sw = 4'b0111;
        cyc(0); cyc(0); cyc(0); cyc(0);
        check_eq("pre_rst_move", o_state, 1);
        i_rst = 1'b0;
        cyc(1);
        check_eq("midrst_step", o_step, 0);
        check_eq("midrst_state", o_state, 0);
        check_eq("midrst_color", o_color, 0);
        i_rst = 1'b1;
        cyc(0);
        check_eq("midrst_step_after", o_step, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
